// File: rtl/reg_bank.sv
// Bank of DEPTH WIDTH-bit registers with one in-place-operation write port
// and two independently enabled combinational read ports.
module reg_bank #(
   parameter int                 WIDTH     = 8,
   parameter int                 DEPTH     = 4,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [2:0]                    op,
   input  logic [$clog2(DEPTH)-1:0]      wr_addr,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic [$clog2(DEPTH)-1:0]      rd_addr_a,
   input  logic                          oe_a,
   output logic [WIDTH-1:0]              q_a,
   input  logic [$clog2(DEPTH)-1:0]      rd_addr_b,
   input  logic                          oe_b,
   output logic [WIDTH-1:0]              q_b,
   output logic                          carry,
   output logic                          zero
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_SHL   = 3'b100;
   localparam logic [2:0] OP_SHR   = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;

   logic [WIDTH-1:0] regs [DEPTH];

   logic             wr_valid;
   logic             rd_valid_a;
   logic             rd_valid_b;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] res;
   logic [WIDTH:0]   ext;
   logic             res_carry;
   logic             exec;

   assign wr_valid   = ({1'b0, wr_addr}   < DEPTH_C);
   assign rd_valid_a = ({1'b0, rd_addr_a} < DEPTH_C);
   assign rd_valid_b = ({1'b0, rd_addr_b} < DEPTH_C);

   // Out-of-range addresses read as zero so nothing undefined leaks into the op.
   assign cur = wr_valid ? regs[wr_addr] : '0;

   always_comb begin
      res       = cur;
      res_carry = 1'b0;
      exec      = 1'b0;
      ext       = '0;
      case (op)
         OP_LOAD: begin
            res  = wr_data;
            exec = 1'b1;
         end
         OP_INC: begin
            ext       = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
            res       = ext[WIDTH-1:0];
            res_carry = ext[WIDTH];
            exec      = 1'b1;
         end
         OP_DEC: begin
            // Borrow shows up as the extra MSB when subtracting from zero.
            ext       = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};
            res       = ext[WIDTH-1:0];
            res_carry = ext[WIDTH];
            exec      = 1'b1;
         end
         OP_SHL: begin
            res       = {cur[WIDTH-2:0], 1'b0};
            res_carry = cur[WIDTH-1];
            exec      = 1'b1;
         end
         OP_SHR: begin
            res       = {1'b0, cur[WIDTH-1:1]};
            res_carry = cur[0];
            exec      = 1'b1;
         end
         OP_CLEAR: begin
            res  = '0;
            exec = 1'b1;
         end
         default: begin
            exec = 1'b0;
         end
      endcase
      if (!wr_valid) exec = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs  <= '{default: RESET_VAL};
         carry <= 1'b0;
         zero  <= (RESET_VAL == '0);
      end else if (exec) begin
         regs[wr_addr] <= res;
         carry         <= res_carry;
         zero          <= (res == '0);
      end
   end

   assign q_a = (oe_a && rd_valid_a) ? regs[rd_addr_a] : '0;
   assign q_b = (oe_b && rd_valid_b) ? regs[rd_addr_b] : '0;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed vector table, hand-written corner sequences,
// and a randomized run against an arithmetic reference model.
module tb_reg_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] op;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [1:0] rd_addr_a, rd_addr_b;
   logic       oe_a, oe_b;
   logic [7:0] q_a, q_b, q3_a, q3_b;
   logic       carry, zero, carry3, zero3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_bank #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .oe_a(oe_a), .q_a(q_a),
      .rd_addr_b(rd_addr_b), .oe_b(oe_b), .q_b(q_b),
      .carry(carry), .zero(zero)
   );

   reg_bank #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut3 (
      .clk(clk), .rst_n(rst_n), .op(op), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .oe_a(oe_a), .q_a(q3_a),
      .rd_addr_b(rd_addr_b), .oe_b(oe_b), .q_b(q3_b),
      .carry(carry3), .zero(zero3)
   );

   typedef struct {
      logic [2:0] op;
      logic [1:0] wa;
      logic [7:0] wd;
      logic [1:0] ra;
      logic [7:0] exp_q;
      logic       exp_c;
      logic       exp_z;
   } vec_t;

   vec_t vecs [$];

   // Reference model state
   int model [4];
   int m_carry;
   int m_zero;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d,
                        input logic [1:0] ra, input logic [1:0] rb);
      @(negedge clk);
      op = o; wr_addr = a; wr_data = d; rd_addr_a = ra; rd_addr_b = rb;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) model[i] = 0;
      m_carry = 0;
      m_zero  = 1;
   endtask

   task automatic model_op(input int o, input int a, input int d);
      int r, n, c;
      r = model[a];
      n = r; c = 0;
      case (o)
         1: begin n = d;             c = 0;              end
         2: begin n = (r + 1) % 256;  c = (r == 255);     end
         3: begin n = (r + 255) % 256; c = (r == 0);      end
         4: begin n = (r * 2) % 256;  c = r / 128;        end
         5: begin n = r / 2;          c = r % 2;          end
         6: begin n = 0;              c = 0;              end
         default: return;
      endcase
      model[a] = n;
      m_carry  = c;
      m_zero   = (n == 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      op = 3'b000;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0; op = '0; wr_addr = '0; wr_data = '0;
      rd_addr_a = '0; rd_addr_b = '0; oe_a = 1'b1; oe_b = 1'b1;
      #12;
      check("reset_q_a", q_a, 8'h00);
      check("reset_carry", carry, 1'b0);
      check("reset_zero", zero, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{3'b001, 2'd2, 8'hAB, 2'd2, 8'hAB, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 2'd0, 8'h00, 2'd1, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 2'd0, 8'h00, 2'd3, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{3'b001, 2'd1, 8'hFF, 2'd1, 8'hFF, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 2'd1, 8'h00, 2'd1, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{3'b011, 2'd1, 8'h00, 2'd1, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{3'b001, 2'd0, 8'h81, 2'd0, 8'h81, 1'b0, 1'b0});
      vecs.push_back('{3'b100, 2'd0, 8'h00, 2'd0, 8'h02, 1'b1, 1'b0});
      vecs.push_back('{3'b101, 2'd0, 8'h00, 2'd0, 8'h01, 1'b0, 1'b0});
      vecs.push_back('{3'b101, 2'd0, 8'h00, 2'd0, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{3'b001, 2'd3, 8'hCD, 2'd3, 8'hCD, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 2'd3, 8'h55, 2'd3, 8'hCD, 1'b0, 1'b0});
      vecs.push_back('{3'b111, 2'd3, 8'h55, 2'd3, 8'hCD, 1'b0, 1'b0});
      vecs.push_back('{3'b111, 2'd3, 8'h00, 2'd3, 8'hCD, 1'b0, 1'b0});
      vecs.push_back('{3'b110, 2'd3, 8'h77, 2'd3, 8'h00, 1'b0, 1'b1});
      vecs.push_back('{3'b111, 2'd3, 8'h77, 2'd3, 8'h00, 1'b0, 1'b1});
      vecs.push_back('{3'b011, 2'd3, 8'h00, 2'd3, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{3'b000, 2'd3, 8'h00, 2'd3, 8'hFF, 1'b1, 1'b0});
      vecs.push_back('{3'b000, 2'd0, 8'h00, 2'd2, 8'hAB, 1'b1, 1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].op, vecs[i].wa, vecs[i].wd, vecs[i].ra, 2'd0);
         check($sformatf("vec%0d_q", i), q_a, vecs[i].exp_q);
         check($sformatf("vec%0d_carry", i), carry, vecs[i].exp_c);
         check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_z);
      end

      // Output enables: both ports on reg3, only B enabled
      apply(3'b001, 2'd3, 8'hCD, 2'd3, 2'd3);
      oe_a = 1'b0;
      #1;
      check("oe_a_off", q_a, 8'h00);
      check("oe_b_on", q_b, 8'hCD);
      oe_a = 1'b1;

      // No bypass: old value before the edge, new value after
      apply(3'b001, 2'd2, 8'h12, 2'd0, 2'd2);
      @(negedge clk);
      op = 3'b010; wr_addr = 2'd2; rd_addr_b = 2'd2;
      #1;
      check("nobypass_before", q_b, 8'h12);
      @(posedge clk);
      #1;
      check("nobypass_after", q_b, 8'h13);
      op = 3'b000;

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         rd_addr_a = 2'(i); rd_addr_b = 2'(3 - i);
         #1;
         check($sformatf("async_rst_qa%0d", i), q_a, 8'h00);
         check($sformatf("async_rst_qb%0d", i), q_b, 8'h00);
      end
      check("async_rst_carry", carry, 1'b0);
      check("async_rst_zero", zero, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // DEPTH=3 instance: writes to address 3 are ignored entirely
      apply(3'b001, 2'd1, 8'h05, 2'd1, 2'd3);
      check("d3_load1", q3_a, 8'h05);
      apply(3'b001, 2'd3, 8'h77, 2'd3, 2'd1);
      check("d3_rd3", q3_a, 8'h00);
      check("d3_reg1_kept", q3_b, 8'h05);
      check("d3_carry_kept", carry3, 1'b0);
      check("d3_zero_kept", zero3, 1'b0);
      apply(3'b110, 2'd3, 8'h00, 2'd3, 2'd1);
      check("d3_clr3_zero_kept", zero3, 1'b0);
      check("d3_clr3_reg1", q3_b, 8'h05);

      // Randomized run against the reference model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int o, a, d, ra, rb;
         logic ea, eb;
         o  = $urandom_range(0, 7);
         a  = $urandom_range(0, 3);
         d  = (n % 16 == 0) ? 255 : $urandom_range(0, 255);
         ra = $urandom_range(0, 3);
         rb = $urandom_range(0, 3);
         ea = 1'($urandom_range(0, 3) != 0);
         eb = 1'($urandom_range(0, 3) != 0);
         oe_a = ea; oe_b = eb;
         apply(3'(o), 2'(a), 8'(d), 2'(ra), 2'(rb));
         model_op(o, a, d);
         check("rnd_q_a", q_a, ea ? 32'(model[ra]) : 32'h0);
         check("rnd_q_b", q_b, eb ? 32'(model[rb]) : 32'h0);
         check("rnd_carry", carry, 32'(m_carry));
         check("rnd_zero", zero, 32'(m_zero));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
